// File: rtl/buf_demux_if.sv
// Byte-bus and pixel-side signals of the R/G/B demultiplexer.
// slave = demux side, master = bus driver / pixel consumer side.
interface buf_demux_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) ();
    logic [DATA_W-1:0] buf_dat;
    logic              buf_vld;
    logic              buf_sof;
    logic              buf_rdy;
    logic              sel_r;
    logic              sel_g;
    logic              sel_b;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
    logic              pix_vld;
    logic              pix_rdy;
    logic              sync_err;
    logic [CNT_W-1:0]  pix_cnt;

    modport slave (
        input  buf_dat, buf_vld, buf_sof, pix_rdy,
        output buf_rdy, sel_r, sel_g, sel_b, r, g, b, pix_vld, sync_err, pix_cnt
    );

    modport master (
        output buf_dat, buf_vld, buf_sof, pix_rdy,
        input  buf_rdy, sel_r, sel_g, sel_b, r, g, b, pix_vld, sync_err, pix_cnt
    );
endinterface

// File: rtl/buf_demux.sv
// Reassembles an R,G,B byte stream into pixels with one-hot channel select and SOF resync.
// Latency: B byte taken at cycle N -> pix_vld at N+1; one byte/cycle sustained.
// Backpressure: buf_rdy drops only in B phase while the output pixel is held (SOF bytes still accepted).
module buf_demux #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    buf_demux_if.slave  bus
);
    localparam logic [2:0] PH_R = 3'b001;
    localparam logic [2:0] PH_G = 3'b010;
    localparam logic [2:0] PH_B = 3'b100;

    logic [2:0]        phase;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] g_hold;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] g_q;
    logic [DATA_W-1:0] b_q;
    logic              pix_vld_q;
    logic              sync_err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              buf_rdy;
    logic              take;
    logic              handoff;

    // An SOF byte never touches the output regs, so it may enter even when the output is full.
    assign buf_rdy = (phase != PH_B) || !pix_vld_q || bus.pix_rdy || (bus.buf_vld && bus.buf_sof);
    assign take    = bus.buf_vld && buf_rdy;
    assign handoff = pix_vld_q && bus.pix_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= PH_R;
            r_hold     <= '0;
            g_hold     <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            pix_vld_q  <= 1'b0;
            sync_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_err_q <= 1'b0;
            if (handoff) begin
                pix_vld_q <= 1'b0;
                cnt_q     <= cnt_q + CNT_W'(1);
            end
            if (take) begin
                if (bus.buf_sof) begin
                    r_hold     <= bus.buf_dat;
                    phase      <= PH_G;
                    sync_err_q <= (phase != PH_R);
                end else begin
                    case (phase)
                        PH_R: begin
                            r_hold <= bus.buf_dat;
                            phase  <= PH_G;
                        end
                        PH_G: begin
                            g_hold <= bus.buf_dat;
                            phase  <= PH_B;
                        end
                        PH_B: begin
                            r_q       <= r_hold;
                            g_q       <= g_hold;
                            b_q       <= bus.buf_dat;
                            pix_vld_q <= 1'b1;
                            phase     <= PH_R;
                        end
                        default: phase <= PH_R;
                    endcase
                end
            end
        end
    end

    assign bus.buf_rdy  = buf_rdy;
    assign bus.sel_r    = phase[0];
    assign bus.sel_g    = phase[1];
    assign bus.sel_b    = phase[2];
    assign bus.r        = r_q;
    assign bus.g        = g_q;
    assign bus.b        = b_q;
    assign bus.pix_vld  = pix_vld_q;
    assign bus.sync_err = sync_err_q;
    assign bus.pix_cnt  = cnt_q;
endmodule
